// File: rtl/decoder_mem_arbiter.sv
// Three-requester round-robin arbiter onto a single memory port, with an in-order
// ID FIFO that routes each memory response back to the requester that issued it.
module decoder_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int MAX_OUTST  = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [2:0]                req_valid_i,
  input  logic [3*ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [3*DATA_WIDTH/8-1:0] req_wmask_i,
  input  logic [3*DATA_WIDTH-1:0]   req_data_i,
  input  logic [2:0]                req_cmd_i,
  output logic [2:0]                req_ready_o,
  output logic [2:0]                rsp_valid_o,
  output logic [DATA_WIDTH-1:0]     rsp_data_o,
  output logic                      rsp_err_o,
  output logic                      mem_req_valid_o,
  output logic [ADDR_WIDTH-1:0]     mem_req_addr_o,
  output logic [DATA_WIDTH/8-1:0]   mem_req_wmask_o,
  output logic [DATA_WIDTH-1:0]     mem_req_data_o,
  output logic                      mem_req_cmd_o,
  input  logic                      mem_req_ready_i,
  input  logic                      mem_rsp_valid_i,
  input  logic [DATA_WIDTH-1:0]     mem_rsp_data_i,
  input  logic                      mem_rsp_err_i,
  output logic [$clog2(MAX_OUTST):0] outst_cnt_o,
  output logic                      orphan_err_o
);

  localparam int MASK_WIDTH = DATA_WIDTH / 8;
  localparam int PTR_W      = $clog2(MAX_OUTST);
  localparam int CNT_W      = PTR_W + 1;

  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } lock_state_t;

  lock_state_t       lock_state, lock_state_nxt;
  logic [1:0]        last_grant;
  logic [1:0]        locked_id;
  logic [1:0]        id_fifo [MAX_OUTST];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  cnt;
  logic              orphan_q;

  logic [1:0]        rr_id;
  logic              rr_valid;
  logic [1:0]        grant;
  logic              grant_valid;
  logic              fifo_full, fifo_empty;
  logic              handshake;
  logic              push, pop;
  logic [1:0]        head_id;

  assign fifo_full  = (cnt == CNT_W'(MAX_OUTST));
  assign fifo_empty = (cnt == '0);
  assign head_id    = id_fifo[rd_ptr];

  // Round-robin search beginning one past the last granted requester.
  always_comb begin
    logic [1:0] cand;
    rr_valid = 1'b0;
    rr_id    = 2'd0;
    cand     = 2'd0;
    for (int unsigned k = 1; k <= 3; k++) begin
      cand = 2'((32'(last_grant) + k) % 3);
      if (!rr_valid && req_valid_i[cand]) begin
        rr_valid = 1'b1;
        rr_id    = cand;
      end
    end
  end

  always_comb begin
    if (lock_state == ST_LOCKED) begin
      grant       = locked_id;
      grant_valid = req_valid_i[locked_id];
    end else begin
      grant       = rr_id;
      grant_valid = rr_valid;
    end
  end

  always_comb begin
    mem_req_valid_o = grant_valid && !fifo_full && !rst_i;
    mem_req_addr_o  = '0;
    mem_req_wmask_o = '0;
    mem_req_data_o  = '0;
    mem_req_cmd_o   = 1'b0;
    req_ready_o     = '0;
    for (int unsigned n = 0; n < 3; n++) begin
      if (grant_valid && grant == 2'(n)) begin
        mem_req_addr_o  = req_addr_i[n*ADDR_WIDTH +: ADDR_WIDTH];
        mem_req_wmask_o = req_wmask_i[n*MASK_WIDTH +: MASK_WIDTH];
        mem_req_data_o  = req_data_i[n*DATA_WIDTH +: DATA_WIDTH];
        mem_req_cmd_o   = req_cmd_i[n];
        req_ready_o[n]  = mem_req_ready_i && !fifo_full && !rst_i;
      end
    end
  end

  assign handshake = mem_req_valid_o && mem_req_ready_i;
  assign push      = handshake;
  assign pop       = mem_rsp_valid_i && !fifo_empty && !rst_i;

  assign rsp_valid_o  = pop ? (3'b001 << head_id) : 3'b000;
  assign rsp_data_o   = mem_rsp_data_i;
  assign rsp_err_o    = mem_rsp_err_i;
  assign outst_cnt_o  = cnt;
  assign orphan_err_o = orphan_q;

  always_comb begin
    lock_state_nxt = lock_state;
    case (lock_state)
      ST_IDLE:   if (mem_req_valid_o && !mem_req_ready_i) lock_state_nxt = ST_LOCKED;
      ST_LOCKED: if (handshake) lock_state_nxt = ST_IDLE;
      default:   lock_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_state <= ST_IDLE;
      locked_id  <= 2'd0;
      last_grant <= 2'd2;
    end else begin
      lock_state <= lock_state_nxt;
      if (lock_state == ST_IDLE && lock_state_nxt == ST_LOCKED) locked_id <= grant;
      if (handshake) last_grant <= grant;
    end
  end

  // A simultaneous push and pop leaves the count unchanged; full uses the pre-pop count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      orphan_q <= 1'b0;
      for (int unsigned i = 0; i < MAX_OUTST; i++) id_fifo[i] <= 2'd0;
    end else begin
      if (push) begin
        id_fifo[wr_ptr] <= grant;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
      if (mem_rsp_valid_i && fifo_empty) orphan_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_decoder_mem_arbiter.sv
// Directed bench for decoder_mem_arbiter: expected response IDs are queued at
// issue time and popped when the memory response is presented.
module tb_decoder_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int MW = DW / 8;
  localparam int MO = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [2:0]        req_valid;
  logic [3*AW-1:0]   req_addr;
  logic [3*MW-1:0]   req_wmask;
  logic [3*DW-1:0]   req_data;
  logic [2:0]        req_cmd;
  logic [2:0]        req_ready;
  logic [2:0]        rsp_valid;
  logic [DW-1:0]     rsp_data;
  logic              rsp_err;
  logic              mem_req_valid;
  logic [AW-1:0]     mem_req_addr;
  logic [MW-1:0]     mem_req_wmask;
  logic [DW-1:0]     mem_req_data;
  logic              mem_req_cmd;
  logic              mem_req_ready;
  logic              mem_rsp_valid;
  logic [DW-1:0]     mem_rsp_data;
  logic              mem_rsp_err;
  logic [$clog2(MO):0] outst_cnt;
  logic              orphan_err;

  int unsigned sb[$];
  int          checks   = 0;
  int          pass_cnt = 0;
  int          fail_cnt = 0;

  decoder_mem_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .MAX_OUTST (MO)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_valid_i    (req_valid),
    .req_addr_i     (req_addr),
    .req_wmask_i    (req_wmask),
    .req_data_i     (req_data),
    .req_cmd_i      (req_cmd),
    .req_ready_o    (req_ready),
    .rsp_valid_o    (rsp_valid),
    .rsp_data_o     (rsp_data),
    .rsp_err_o      (rsp_err),
    .mem_req_valid_o(mem_req_valid),
    .mem_req_addr_o (mem_req_addr),
    .mem_req_wmask_o(mem_req_wmask),
    .mem_req_data_o (mem_req_data),
    .mem_req_cmd_o  (mem_req_cmd),
    .mem_req_ready_i(mem_req_ready),
    .mem_rsp_valid_i(mem_rsp_valid),
    .mem_rsp_data_i (mem_rsp_data),
    .mem_rsp_err_i  (mem_rsp_err),
    .outst_cnt_o    (outst_cnt),
    .orphan_err_o   (orphan_err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [AW-1:0] addr_of(input int unsigned n);
    return 32'h1000 + 32'(n) * 32'h100;
  endfunction

  function automatic logic [DW-1:0] data_of(input int unsigned n);
    return 64'hDA7A_0000_0000_0000 + 64'(n) * 64'h1111;
  endfunction

  function automatic logic [MW-1:0] wmask_of(input int unsigned n);
    return 8'h11 << n;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one request cycle with ready high and expect exp_id to be granted.
  task automatic issue(input logic [2:0] valid, input int unsigned exp_id);
    req_valid     = valid;
    mem_req_ready = 1'b1;
    #1;
    check("grant_ready", 64'(req_ready), 64'(3'b001 << exp_id));
    check("grant_valid", 64'(mem_req_valid), 64'd1);
    check("grant_addr", 64'(mem_req_addr), 64'(addr_of(exp_id)));
    check("grant_data", mem_req_data, data_of(exp_id));
    check("grant_wmask", 64'(mem_req_wmask), 64'(wmask_of(exp_id)));
    check("grant_cmd", 64'(mem_req_cmd), 64'(req_cmd[exp_id]));
    sb.push_back(exp_id);
    tick();
  endtask

  task automatic respond(input logic [DW-1:0] d, input logic e);
    int unsigned id;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = d;
    mem_rsp_err   = e;
    #1;
    if (sb.size() == 0) begin
      check("orphan_rsp_valid", 64'(rsp_valid), 64'd0);
    end else begin
      id = sb.pop_front();
      check("rsp_valid", 64'(rsp_valid), 64'(3'b001 << id));
    end
    check("rsp_data", rsp_data, d);
    check("rsp_err", 64'(rsp_err), 64'(e));
    tick();
    mem_rsp_valid = 1'b0;
    mem_rsp_err   = 1'b0;
  endtask

  initial begin
    for (int n = 0; n < 3; n++) begin
      req_addr[n*AW +: AW]  = addr_of(n);
      req_data[n*DW +: DW]  = data_of(n);
      req_wmask[n*MW +: MW] = wmask_of(n);
    end
    req_cmd       = 3'b101;
    rst           = 1'b1;
    req_valid     = 3'b111;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    mem_rsp_err   = 1'b0;

    // Reset state
    #3;
    check("rst_cnt", 64'(outst_cnt), 64'd0);
    check("rst_orphan", 64'(orphan_err), 64'd0);
    check("rst_mem_valid", 64'(mem_req_valid), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    req_valid = 3'b000;
    tick();
    rst = 1'b0;
    tick();
    check("idle_mem_valid", 64'(mem_req_valid), 64'd0);
    check("idle_addr", 64'(mem_req_addr), 64'd0);

    // All three valid: grants 0,1,2
    for (int unsigned i = 0; i < 3; i++) issue(3'b111, i);
    req_valid     = 3'b000;
    mem_req_ready = 1'b0;
    check("cnt_after_3", 64'(outst_cnt), 64'd3);
    respond(64'h11, 1'b0);
    respond(64'h22, 1'b1);
    respond(64'h33, 1'b0);
    check("cnt_drained", 64'(outst_cnt), 64'd0);

    // IDs 2,0,1 then responses A,B,C
    issue(3'b100, 2);
    issue(3'b001, 0);
    issue(3'b010, 1);
    req_valid = 3'b000;
    respond(64'hA, 1'b0);
    respond(64'hB, 1'b0);
    respond(64'hC, 1'b0);
    check("cnt_abc", 64'(outst_cnt), 64'd0);

    // Lock: requester 1 stalled, requester 0 raised later
    req_valid     = 3'b010;
    mem_req_ready = 1'b0;
    #1;
    check("lock_valid", 64'(mem_req_valid), 64'd1);
    check("lock_addr_c1", 64'(mem_req_addr), 64'(addr_of(1)));
    check("lock_ready_c1", 64'(req_ready), 64'd0);
    tick();
    req_valid = 3'b011;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("lock_addr_hold", 64'(mem_req_addr), 64'(addr_of(1)));
      check("lock_ready_hold", 64'(req_ready), 64'd0);
      tick();
    end
    mem_req_ready = 1'b1;
    #1;
    check("lock_release_ready", 64'(req_ready), 64'b010);
    check("lock_release_addr", 64'(mem_req_addr), 64'(addr_of(1)));
    sb.push_back(1);
    tick();
    issue(3'b001, 0);
    req_valid     = 3'b000;
    mem_req_ready = 1'b0;
    respond(64'h44, 1'b0);
    respond(64'h55, 1'b0);

    // Fill to MAX_OUTST, then blocked while full even with a pop in the same cycle
    for (int i = 0; i < MO; i++) issue(3'b001, 0);
    #1;
    check("full_cnt", 64'(outst_cnt), 64'(MO));
    check("full_mem_valid", 64'(mem_req_valid), 64'd0);
    check("full_ready", 64'(req_ready), 64'd0);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 64'h66;
    #1;
    check("full_pop_ready", 64'(req_ready), 64'd0);
    check("full_pop_rsp", 64'(rsp_valid), 64'(3'b001 << sb.pop_front()));
    tick();
    mem_rsp_valid = 1'b0;
    #1;
    check("after_pop_cnt", 64'(outst_cnt), 64'(MO - 1));
    check("after_pop_ready", 64'(req_ready), 64'b001);
    sb.push_back(0);
    tick();
    check("refill_cnt", 64'(outst_cnt), 64'(MO));
    req_valid = 3'b000;
    for (int i = 0; i < MO - 1; i++) respond(64'h70 + 64'(i), 1'b0);
    check("one_left_cnt", 64'(outst_cnt), 64'd1);
    // Push and pop together: count unchanged
    req_valid     = 3'b001;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 64'h99;
    #1;
    check("pp_rsp", 64'(rsp_valid), 64'(3'b001 << sb.pop_front()));
    check("pp_ready", 64'(req_ready), 64'b001);
    sb.push_back(0);
    tick();
    mem_rsp_valid = 1'b0;
    req_valid     = 3'b000;
    mem_req_ready = 1'b0;
    check("pp_cnt", 64'(outst_cnt), 64'd1);
    respond(64'hAA, 1'b0);
    check("final_drain_cnt", 64'(outst_cnt), 64'd0);

    // Orphan response
    check("orphan_before", 64'(orphan_err), 64'd0);
    respond(64'hBAD, 1'b1);
    check("orphan_set", 64'(orphan_err), 64'd1);
    tick();
    check("orphan_sticky", 64'(orphan_err), 64'd1);

    // Reset mid-burst
    issue(3'b010, 1);
    issue(3'b010, 1);
    req_valid     = 3'b010;
    mem_req_ready = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    sb.delete();
    check("midrst_cnt", 64'(outst_cnt), 64'd0);
    check("midrst_orphan", 64'(orphan_err), 64'd0);
    check("midrst_mem_valid", 64'(mem_req_valid), 64'd0);
    check("midrst_ready", 64'(req_ready), 64'd0);
    req_valid = 3'b000;
    tick();
    rst = 1'b0;
    respond(64'hDEAD, 1'b0);
    check("post_rst_orphan", 64'(orphan_err), 64'd1);
    issue(3'b111, 0);
    check("post_rst_cnt", 64'(outst_cnt), 64'd1);

    $display("%0d/%0d checks passed", pass_cnt, checks);
    $finish;
  end

endmodule

// File: doc/decoder_mem_arbiter.md
DECODER_MEM_ARBITER -- requirements
Module: decoder_mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: request address width.
REQ-002 Parameter DATA_WIDTH, default 64: request/response data width; wmask width is DATA_WIDTH/8.
REQ-003 Parameter MAX_OUTST, default 4: maximum in-flight requests; power of two, at least 2.
REQ-004 clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst_i  in  1  asynchronous, active-high reset.
REQ-006 req_valid_i  in  3  per-requester request valid; bit0 bitstream, bit1 RAM0, bit2 RAM1.
REQ-007 req_addr_i  in  3*ADDR_WIDTH  per-requester address, requester n at slice n.
REQ-008 req_wmask_i  in  3*DATA_WIDTH/8  per-requester byte write mask.
REQ-009 req_data_i  in  3*DATA_WIDTH  per-requester write data.
REQ-010 req_cmd_i  in  3  per-requester command; 1 = write, 0 = read.
REQ-011 req_ready_o  out  3  per-requester accept; at most one bit high per cycle.
REQ-012 rsp_valid_o  out  3  per-requester response strobe; at most one bit high per cycle.
REQ-013 rsp_data_o  out  DATA_WIDTH  response data, shared by all requesters.
REQ-014 rsp_err_o  out  1  response error, qualified by any rsp_valid_o bit.
REQ-015 mem_req_valid_o / mem_req_addr_o / mem_req_wmask_o / mem_req_data_o / mem_req_cmd_o  out  1/ADDR_WIDTH/DATA_WIDTH/8/DATA_WIDTH/1  shared memory request.
REQ-016 mem_req_ready_i  in  1  memory accept.
REQ-017 mem_rsp_valid_i / mem_rsp_data_i / mem_rsp_err_i  in  1/DATA_WIDTH/1  memory response, in request order.
REQ-018 outst_cnt_o  out  $clog2(MAX_OUTST)+1  current in-flight count.
REQ-019 orphan_err_o  out  1  sticky flag: a response arrived with nothing in flight.

Function
REQ-020 A handshake occurs on a cycle with mem_req_valid_o and mem_req_ready_i both high; the request fields are forwarded combinationally from the selected requester, so request latency is 0 cycles.
REQ-021 Arbitration is round-robin with a 2-bit last-grant pointer:
- search order starts at pointer+1 mod 3;
- the pointer updates only on a handshake, to the granted index.
REQ-022 Once mem_req_valid_o is asserted without mem_req_ready_i, the grant is locked, and the address, wmask, data and cmd stay on the same requester until the handshake.
- Lock state is IDLE/LOCKED: IDLE->LOCKED on valid&&!ready; LOCKED->IDLE on the handshake.
- Requesters shall hold valid and payload while unaccepted.
REQ-023 req_ready_o[n] = mem_req_ready_i && grant==n && !fifo_full; mem_req_valid_o is forced low while the ID FIFO is full.
REQ-024 Every handshake (read or write) pushes the 2-bit granted ID into an in-order ID FIFO of depth MAX_OUTST; every write also yields exactly one response.
REQ-025 On mem_rsp_valid_i with FIFO non-empty:
- rsp_valid_o[head ID] is pulsed in the same cycle (0-cycle response latency), the head is popped, and data and err are passed through unchanged;
- the requester has no backpressure on responses.
REQ-026 On mem_rsp_valid_i with FIFO empty, the response is dropped, no rsp_valid_o bit is asserted, and orphan_err_o is set until reset.
REQ-027 On a cycle with both a push and a pop, the count is unchanged.
- Full is evaluated on the registered count before the pop, so a full FIFO blocks the grant even if a pop occurs in the same cycle.
REQ-028 FIFO read and write pointers wrap modulo MAX_OUTST, and outst_cnt_o ranges from 0 to MAX_OUTST.
REQ-029 With no valid requester, mem_req_valid_o = 0 and the request fields are driven 0.

Reset
REQ-030 While rst_i is high, asynchronously:
- last-grant pointer = 2, so requester 0 wins first;
- lock state = IDLE; FIFO pointers and count = 0;
- orphan_err_o = 0; all rsp_valid_o, req_ready_o and mem_req_valid_o = 0.
REQ-031 Reset mid-transaction discards all in-flight IDs; responses after reset are orphans (see REQ-026).

Verification
REQ-032 After reset, all three requesters valid and mem_req_ready_i = 1 for 3 cycles -> grants in order 0,1,2 and outst_cnt_o = 3.
REQ-033 Requester 1 valid with mem_req_ready_i = 0 for 4 cycles, requester 0 raised in cycle 2 -> mem_req_addr_o stays on requester 1's address until ready, then requester 0 is granted.
REQ-034 MAX_OUTST = 4, 4 reads accepted, no responses -> mem_req_valid_o = 0 and req_ready_o = 000. One response with a new request in the same cycle -> the new request is not accepted that cycle and is accepted the next cycle.
REQ-035 Issue IDs 2,0,1, then 3 responses with data 0xA,0xB,0xC -> rsp_valid_o = 100,001,010 carrying 0xA,0xB,0xC respectively, and outst_cnt_o returns to 0.
REQ-036 mem_rsp_valid_i with err = 1 while empty -> orphan_err_o rises next edge, rsp_valid_o = 000; rst_i pulse mid-burst -> all state is cleared within the same cycle.
